// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage between pc and the IF/ID register.
// Runs a single-outstanding req/gnt/rvalid transaction, squashes fetches
// on jump, and parks one response in a skid register while held.
module ifu_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013,
  parameter logic [2:0]        HOLD_IF  = 3'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag_i,
  input  logic [2:0]        hold_flag_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              squash_q, squash_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_valid_q, inst_valid_d;

  logic hold;
  logic in_req;
  logic in_wait;
  logic req;
  logic granted;
  logic rsp;
  logic rsp_keep;
  logic rsp_out;
  logic skid_out;
  logic deliver;

  // Bus handshake, delivery decode and stall request
  always_comb begin
    hold     = (hold_flag_i >= HOLD_IF);
    in_req   = (state_q == S_REQ);
    in_wait  = (state_q == S_WAIT);
    req      = rst && in_req && !skid_valid_q && !hold;
    granted  = req && ibus_gnt_i;
    rsp      = rst && in_wait && ibus_rvalid_i;
    rsp_keep = rsp && !squash_q && !jump_flag_i;
    rsp_out  = rsp_keep && !hold;
    skid_out = skid_valid_q && !hold && !jump_flag_i;
    deliver  = rsp_out || skid_out;

    ibus_req_o  = req;
    ibus_addr_o = (rst && in_req) ? pc_i : '0;
    stall_req_o = rst && (in_req || in_wait) && !deliver;
  end

  // Next-state logic for the FSM, squash flag, skid buffer and outputs
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    squash_d     = squash_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_addr_d  = skid_addr_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (granted) begin
          req_addr_d = pc_i;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ibus_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // A response arriving alongside a jump is itself the discarded one, so
    // squash is only armed when the response is still outstanding.
    if (rsp) squash_d = 1'b0;
    if (jump_flag_i && ((in_wait && !ibus_rvalid_i) || granted)) squash_d = 1'b1;

    if (jump_flag_i) begin
      skid_valid_d = 1'b0;
    end else if (skid_out) begin
      skid_valid_d = 1'b0;
    end else if (rsp_keep && hold) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ibus_rdata_i;
      skid_addr_d  = req_addr_q;
    end

    if (jump_flag_i) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end else if (skid_out) begin
      inst_d       = skid_data_q;
      inst_addr_d  = skid_addr_q;
      inst_valid_d = 1'b1;
    end else if (rsp_out) begin
      inst_d       = ibus_rdata_i;
      inst_addr_d  = req_addr_q;
      inst_valid_d = 1'b1;
    end else if (!hold) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      squash_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_addr_q  <= '0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      squash_q     <= squash_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_addr_q  <= skid_addr_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch: tb acts as pc and as instruction memory
// returning addr ^ 32'hA5A5_0000.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic [2:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        stall_req_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pc;
  logic [31:0] jump_target;
  logic [31:0] pend_addr;
  bit          fetch_active;
  bit          pend;
  int          pend_cnt;
  int          wait_cnt;
  int          gnt_delay;
  int          rsp_delay;

  ifu_fetch #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NOP_INST(32'h0000_0013),
    .HOLD_IF (3'd2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .jump_flag_i  (jump_flag_i),
    .hold_flag_i  (hold_flag_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .stall_req_o  (stall_req_o)
  );

  always #5 clk = ~clk;

  // One clock: sample bus/stall before the edge, then play memory and pc.
  task automatic step();
    logic r, g, st;
    logic [31:0] a;
    r  = ibus_req_o;
    g  = ibus_req_o & ibus_gnt_i;
    a  = ibus_addr_o;
    st = stall_req_o;
    @(posedge clk);
    #1;
    if (r === 1'b1) fetch_active = 1'b1;
    if (r === 1'b1 && g !== 1'b1) wait_cnt++;
    else if (g === 1'b1) wait_cnt = 0;
    if (g === 1'b1) begin
      pend      = 1'b1;
      pend_cnt  = rsp_delay;
      pend_addr = a;
    end
    if (!rst) begin
      fetch_active = 1'b0;
      pend         = 1'b0;
      wait_cnt     = 0;
    end
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = pend_addr ^ K;
        pend          = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (jump_flag_i) pc = jump_target;
    else if (fetch_active && st === 1'b0) pc = pc + 32'd4;
    jump_flag_i = 1'b0;
    ibus_gnt_i  = (wait_cnt >= gnt_delay);
    pc_i        = pc;
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst         = 1'b0;
    jump_flag_i = 1'b0;
    hold_flag_i = 3'd0;
    gnt_delay   = 0;
    rsp_delay   = 0;
    pc          = start;
    pc_i        = start;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    hold_flag_i = 3'd0;
    gnt_delay   = 0;
    pc          = 32'h0000_1234;
    pc_i        = pc;
    step();
    step();
    if (ibus_req_o !== 1'b0) begin $display("FAIL rst_req: got %b want 0", ibus_req_o); n_fail++; end
    n_checks++;
    if (ibus_addr_o !== 32'h0) begin $display("FAIL rst_addr: got %h want 0", ibus_addr_o); n_fail++; end
    n_checks++;
    if (inst_o !== NOP) begin $display("FAIL rst_inst: got %h want %h", inst_o, NOP); n_fail++; end
    n_checks++;
    if (inst_addr_o !== 32'h0) begin $display("FAIL rst_iaddr: got %h want 0", inst_addr_o); n_fail++; end
    n_checks++;
    if (inst_valid_o !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", inst_valid_o); n_fail++; end
    n_checks++;
    if (stall_req_o !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", stall_req_o); n_fail++; end
    n_checks++;
    rst  = 1'b1;
    pc   = 32'h0;
    pc_i = 32'h0;
    #1;
    if (stall_req_o !== 1'b0 || ibus_req_o !== 1'b0) begin
      $display("FAIL idle_out: got stall=%b req=%b want 0/0", stall_req_o, ibus_req_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] ea;
    do_reset(32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      ea = 32'(k) * 32'd4;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== ea) begin
        $display("FAIL zw_req[%0d]: got req=%b addr=%h want 1/%h", k, ibus_req_o, ibus_addr_o, ea); n_fail++;
      end
      n_checks++;
      if (stall_req_o !== 1'b1) begin $display("FAIL zw_stall_req[%0d]: got %b want 1", k, stall_req_o); n_fail++; end
      n_checks++;
      if (k > 0) begin
        ea = 32'(k - 1) * 32'd4;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== ea || inst_o !== (ea ^ K)) begin
          $display("FAIL zw_out[%0d]: got v=%b a=%h i=%h want 1/%h/%h", k, inst_valid_o, inst_addr_o, inst_o, ea, ea ^ K);
          n_fail++;
        end
        n_checks++;
      end
      step();
      if (stall_req_o !== 1'b0) begin $display("FAIL zw_stall_rsp[%0d]: got %b want 0", k, stall_req_o); n_fail++; end
      n_checks++;
      if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
        $display("FAIL zw_gap[%0d]: got v=%b i=%h want 0/%h", k, inst_valid_o, inst_o, NOP); n_fail++;
      end
      n_checks++;
      step();
    end
  endtask

  task automatic test_grant_delay();
    do_reset(32'h10);
    gnt_delay  = 3;
    ibus_gnt_i = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h10 || stall_req_o !== 1'b1 || ibus_gnt_i !== 1'b0) begin
        $display("FAIL gd_wait[%0d]: got req=%b addr=%h stall=%b gnt=%b want 1/10/1/0",
                 k, ibus_req_o, ibus_addr_o, stall_req_o, ibus_gnt_i);
        n_fail++;
      end
      n_checks++;
      step();
    end
    gnt_delay = 0;
    step();
    if (stall_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      $display("FAIL gd_rsp: got stall=%b v=%b want 0/0", stall_req_o, inst_valid_o); n_fail++;
    end
    n_checks++;
    step();
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h10 || inst_o !== 32'hA5A5_0010) begin
      $display("FAIL gd_out: got v=%b a=%h i=%h want 1/10/a5a50010", inst_valid_o, inst_addr_o, inst_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_jump_wait();
    do_reset(32'h40);
    rsp_delay = 2;
    step();
    step();
    if (stall_req_o !== 1'b1 || ibus_req_o !== 1'b0) begin
      $display("FAIL jw_wait: got stall=%b req=%b want 1/0", stall_req_o, ibus_req_o); n_fail++;
    end
    n_checks++;
    jump_target = 32'hfefe_abab;
    jump_flag_i = 1'b1;
    step();
    rsp_delay = 0;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
      $display("FAIL jw_nop: got v=%b i=%h want 0/%h", inst_valid_o, inst_o, NOP); n_fail++;
    end
    n_checks++;
    step();
    if (stall_req_o !== 1'b1 || ibus_rvalid_i !== 1'b1) begin
      $display("FAIL jw_drop_stall: got stall=%b rvalid=%b want 1/1", stall_req_o, ibus_rvalid_i); n_fail++;
    end
    n_checks++;
    step();
    if (inst_valid_o !== 1'b0) begin $display("FAIL jw_drop_valid: got %b want 0", inst_valid_o); n_fail++; end
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hfefe_abab) begin
      $display("FAIL jw_redirect: got req=%b addr=%h want 1/fefeabab", ibus_req_o, ibus_addr_o); n_fail++;
    end
    n_checks++;
    step();
    step();
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hfefe_abab || inst_o !== 32'h5b5b_abab) begin
      $display("FAIL jw_out: got v=%b a=%h i=%h want 1/fefeabab/5b5babab", inst_valid_o, inst_addr_o, inst_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_hold_skid();
    do_reset(32'h1c);
    step();
    step();
    step();
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h1c || ibus_addr_o !== 32'h20) begin
      $display("FAIL hs_pre: got v=%b a=%h req_addr=%h want 1/1c/20", inst_valid_o, inst_addr_o, ibus_addr_o); n_fail++;
    end
    n_checks++;
    step();
    hold_flag_i = 3'd3;
    #1;
    if (stall_req_o !== 1'b1) begin $display("FAIL hs_rsp_stall: got %b want 1", stall_req_o); n_fail++; end
    n_checks++;
    step();
    for (int k = 0; k < 2; k++) begin
      if (ibus_req_o !== 1'b0 || stall_req_o !== 1'b1 || inst_valid_o !== 1'b0 ||
          inst_addr_o !== 32'h1c || inst_o !== NOP) begin
        $display("FAIL hs_frozen[%0d]: got req=%b stall=%b v=%b a=%h i=%h want 0/1/0/1c/%h",
                 k, ibus_req_o, stall_req_o, inst_valid_o, inst_addr_o, inst_o, NOP);
        n_fail++;
      end
      n_checks++;
      step();
    end
    hold_flag_i = 3'd0;
    #1;
    if (stall_req_o !== 1'b0 || ibus_req_o !== 1'b0) begin
      $display("FAIL hs_release: got stall=%b req=%b want 0/0", stall_req_o, ibus_req_o); n_fail++;
    end
    n_checks++;
    step();
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h20 || inst_o !== 32'hA5A5_0020) begin
      $display("FAIL hs_out: got v=%b a=%h i=%h want 1/20/a5a50020", inst_valid_o, inst_addr_o, inst_o); n_fail++;
    end
    n_checks++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h24) begin
      $display("FAIL hs_next: got req=%b addr=%h want 1/24", ibus_req_o, ibus_addr_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_jump_hold();
    do_reset(32'h20);
    step();
    step();
    hold_flag_i = 3'd2;
    #1;
    if (stall_req_o !== 1'b1) begin $display("FAIL jh_hold2: got stall=%b want 1", stall_req_o); n_fail++; end
    n_checks++;
    step();
    jump_target = 32'h300;
    jump_flag_i = 1'b1;
    step();
    if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      $display("FAIL jh_held: got req=%b v=%b want 0/0", ibus_req_o, inst_valid_o); n_fail++;
    end
    n_checks++;
    hold_flag_i = 3'd0;
    #1;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h300 || stall_req_o !== 1'b1) begin
      $display("FAIL jh_refetch: got req=%b addr=%h stall=%b want 1/300/1", ibus_req_o, ibus_addr_o, stall_req_o);
      n_fail++;
    end
    n_checks++;
    step();
    if (inst_valid_o !== 1'b0) begin $display("FAIL jh_no_skid: got v=%b want 0", inst_valid_o); n_fail++; end
    n_checks++;
    step();
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h300 || inst_o !== 32'hA5A5_0300) begin
      $display("FAIL jh_out: got v=%b a=%h i=%h want 1/300/a5a50300", inst_valid_o, inst_addr_o, inst_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    do_reset(32'h80);
    rsp_delay = 3;
    step();
    step();
    rst = 1'b0;
    #1;
    if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0 || stall_req_o !== 1'b0) begin
      $display("FAIL rm_comb: got req=%b addr=%h stall=%b want 0/0/0", ibus_req_o, ibus_addr_o, stall_req_o); n_fail++;
    end
    n_checks++;
    step();
    if (inst_o !== NOP || inst_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
      $display("FAIL rm_regs: got i=%h a=%h v=%b want %h/0/0", inst_o, inst_addr_o, inst_valid_o, NOP); n_fail++;
    end
    n_checks++;
    rsp_delay = 0;
    pc        = 32'h0;
    pc_i      = 32'h0;
    rst       = 1'b1;
    #1;
    step();
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
      $display("FAIL rm_restart: got req=%b addr=%h want 1/0", ibus_req_o, ibus_addr_o); n_fail++;
    end
    n_checks++;
    step();
    step();
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== K) begin
      $display("FAIL rm_out: got v=%b a=%h i=%h want 1/0/%h", inst_valid_o, inst_addr_o, inst_o, K); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    rst           = 1'b0;
    pc            = '0;
    pc_i          = '0;
    jump_flag_i   = 1'b0;
    jump_target   = '0;
    hold_flag_i   = 3'd0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = '0;
    pend          = 1'b0;
    pend_addr     = '0;
    pend_cnt      = 0;
    wait_cnt      = 0;
    gnt_delay     = 0;
    rsp_delay     = 0;
    fetch_active  = 1'b0;
    test_reset();
    test_zero_wait();
    test_grant_delay();
    test_jump_wait();
    test_hold_skid();
    test_jump_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
